// File: rtl/uart_word_sender.sv
// rtl/uart_word_sender.sv - pops one FIFO word and sends its bytes to a UART TX over req/busy
module uart_word_sender #(
  parameter int WORD_BYTES  = 2,
  parameter int MSB_FIRST   = 0,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                    SYS_CLK,
  input  logic                    RST_N,
  input  logic                    en,
  input  logic [8*WORD_BYTES-1:0] data_in,
  input  logic                    rd_empty,
  output logic                    rd_req,
  output logic [7:0]              data_out,
  output logic                    tx_req,
  input  logic                    tx_busy,
  output logic                    busy,
  output logic                    word_done,
  output logic                    ack_err
);

  localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int CW = $clog2(ACK_TIMEOUT);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORD_BYTES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_LOAD, S_ACK, S_DONE, S_ERR
  } state_t;

  state_t                  r_state;
  logic [8*WORD_BYTES-1:0] r_latch_data;
  logic [IW-1:0]           r_byte_idx;
  logic [CW-1:0]           r_to_cnt;
  logic                    r_rd_req;
  logic [7:0]              r_data_out;
  logic                    r_tx_req;
  logic                    r_busy;
  logic                    r_word_done;
  logic                    r_ack_err;

  logic [IW-1:0]           w_sel;
  logic [8*WORD_BYTES-1:0] w_shifted;
  logic [7:0]              w_cur_byte;

  // Byte order is resolved by mirroring the index rather than the data.
  always_comb begin
    w_sel      = (MSB_FIRST != 0) ? (LAST_IDX - r_byte_idx) : r_byte_idx;
    w_shifted  = r_latch_data >> {w_sel, 3'b000};
    w_cur_byte = w_shifted[7:0];
  end

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= S_IDLE;
      r_latch_data <= '0;
      r_byte_idx   <= '0;
      r_to_cnt     <= '0;
      r_rd_req     <= 1'b0;
      r_data_out   <= 8'h00;
      r_tx_req     <= 1'b0;
      r_busy       <= 1'b0;
      r_word_done  <= 1'b0;
      r_ack_err    <= 1'b0;
    end else begin
      r_word_done <= 1'b0;
      r_ack_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en && !rd_empty && !tx_busy) begin
            r_rd_req <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_FETCH;
          end else begin
            r_busy   <= 1'b0;
          end
        end
        S_FETCH: begin
          r_rd_req <= 1'b0;
          r_state  <= S_LATCH;
        end
        S_LATCH: begin
          r_latch_data <= data_in;
          r_byte_idx   <= '0;
          r_state      <= S_LOAD;
        end
        S_LOAD: begin
          r_data_out <= w_cur_byte;
          r_tx_req   <= 1'b1;
          r_to_cnt   <= '0;
          r_state    <= S_ACK;
        end
        S_ACK: begin
          // Accept is checked first so it wins over a coincident timeout.
          if (tx_busy) begin
            r_tx_req <= 1'b0;
            r_state  <= S_DONE;
          end else if (r_to_cnt == TO_LAST) begin
            r_tx_req  <= 1'b0;
            r_ack_err <= 1'b1;
            r_state   <= S_ERR;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (!tx_busy) begin
            if (r_byte_idx == LAST_IDX) begin
              r_word_done <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_byte_idx <= r_byte_idx + 1'b1;
              r_state    <= S_LOAD;
            end
          end
        end
        S_ERR: begin
          r_tx_req <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_req    = r_rd_req;
  assign data_out  = r_data_out;
  assign tx_req    = r_tx_req;
  assign busy      = r_busy;
  assign word_done = r_word_done;
  assign ack_err   = r_ack_err;

endmodule

// File: tb/tb_uart_word_sender.sv
// tb/tb_uart_word_sender.sv - directed bench for uart_word_sender (2-byte LSB-first and 4-byte MSB-first)
module tb_uart_word_sender;

  logic clk;
  logic RST_N;

  logic        en_a, empty_a, rd_a, txr_a, txb_a, busy_a, wd_a, ae_a;
  logic [15:0] din_a;
  logic [7:0]  dout_a;
  logic        en_b, empty_b, rd_b, txr_b, txb_b, busy_b, wd_b, ae_b;
  logic [31:0] din_b;
  logic [7:0]  dout_b;

  uart_word_sender #(.WORD_BYTES(2), .MSB_FIRST(0), .ACK_TIMEOUT(1024)) u_dut_a (
    .SYS_CLK(clk), .RST_N(RST_N), .en(en_a), .data_in(din_a), .rd_empty(empty_a),
    .rd_req(rd_a), .data_out(dout_a), .tx_req(txr_a), .tx_busy(txb_a),
    .busy(busy_a), .word_done(wd_a), .ack_err(ae_a));

  uart_word_sender #(.WORD_BYTES(4), .MSB_FIRST(1), .ACK_TIMEOUT(16)) u_dut_b (
    .SYS_CLK(clk), .RST_N(RST_N), .en(en_b), .data_in(din_b), .rd_empty(empty_b),
    .rd_req(rd_b), .data_out(dout_b), .tx_req(txr_b), .tx_busy(txb_b),
    .busy(busy_b), .word_done(wd_b), .ack_err(ae_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [15:0] qa[$];
  logic [31:0] qb[$];
  logic [7:0]  got_a[$];
  logic [7:0]  got_b[$];
  int n_rd_a = 0, n_wd_a = 0, n_ae_a = 0, act_a = 0, viol_a = 0, t_rd_a = 0, t_tx_a = 0;
  int n_rd_b = 0, n_wd_b = 0, n_ae_b = 0, viol_b = 0, t_rd_b = 0, t_tx_b = 0, t_ae_b = 0;
  int ph_a = 0, uc_a = 0, ph_b = 0, uc_b = 0;
  logic pend_a = 1'b0, ptx_a = 1'b0, mute_a = 1'b0;
  logic pend_b = 1'b0, ptx_b = 1'b0, mute_b = 1'b0, ae_txr_b = 1'b0;

  // FIFO, UART TX and monitor model for instance a: busy ~10 cycles after req, held 5
  always @(negedge clk) begin
    if (rd_a) begin
      if (qa.size() > 0) din_a = qa.pop_front();
      t_rd_a = cyc; pend_a = 1'b1; n_rd_a++;
    end
    empty_a = (qa.size() == 0);
    if (wd_a) n_wd_a++;
    if (ae_a) n_ae_a++;
    if (rd_a || txr_a || busy_a) act_a++;
    if (txr_a && !ptx_a) begin
      if (txb_a) viol_a++;
      if (pend_a) begin t_tx_a = cyc; pend_a = 1'b0; end
    end
    ptx_a = txr_a;
    case (ph_a)
      0: if (txr_a && !mute_a) begin uc_a = 1; ph_a = 1; end
      1: if (uc_a == 10) begin txb_a = 1'b1; got_a.push_back(dout_a); uc_a = 1; ph_a = 2; end
         else uc_a++;
      2: if (uc_a == 5) begin txb_a = 1'b0; ph_a = 0; end else uc_a++;
      default: ph_a = 0;
    endcase
  end

  always @(negedge clk) begin
    if (rd_b) begin
      if (qb.size() > 0) din_b = qb.pop_front();
      t_rd_b = cyc; pend_b = 1'b1; n_rd_b++;
    end
    empty_b = (qb.size() == 0);
    if (wd_b) n_wd_b++;
    if (ae_b) begin n_ae_b++; t_ae_b = cyc; ae_txr_b = txr_b; end
    if (txr_b && !ptx_b) begin
      if (txb_b) viol_b++;
      if (pend_b) begin t_tx_b = cyc; pend_b = 1'b0; end
    end
    ptx_b = txr_b;
    case (ph_b)
      0: if (txr_b && !mute_b) begin uc_b = 1; ph_b = 1; end
      1: if (uc_b == 10) begin txb_b = 1'b1; got_b.push_back(dout_b); uc_b = 1; ph_b = 2; end
         else uc_b++;
      2: if (uc_b == 5) begin txb_b = 1'b0; ph_b = 0; end else uc_b++;
      default: ph_b = 0;
    endcase
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_b[8];
    int base_rd, base_wd;
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    RST_N = 1'b0; en_a = 1'b0; en_b = 1'b0;
    din_a = '0; din_b = '0; empty_a = 1'b1; empty_b = 1'b1; txb_a = 1'b0; txb_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_a", {rd_a, txr_a, dout_a, busy_a, wd_a, ae_a}, 13'h0);
    check("reset_b", {rd_b, txr_b, dout_b, busy_b, wd_b, ae_b}, 13'h0);
    RST_N = 1'b1;
    repeat (2) @(negedge clk);

    // 16'hA55A, LSB first
    qa.push_back(16'hA55A);
    en_a = 1'b1;
    for (int i = 0; i < 400 && n_wd_a < 1; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("t1_word_done", n_wd_a, 1);
    check("t1_rd_pulses", n_rd_a, 1);
    check("t1_nbytes", got_a.size(), 2);
    check("t1_byte0", got_a[0], 8'h5A);
    check("t1_byte1", got_a[1], 8'hA5);
    check("t1_latency", t_tx_a - t_rd_a, 3);
    check("t1_busy_low", busy_a, 1'b0);

    // Empty FIFO with en high: nothing moves
    act_a = 0;
    repeat (100) @(negedge clk);
    check("t2_idle_activity", act_a, 0);
    check("t2_rd_pulses", n_rd_a, 1);
    en_a = 1'b0;

    // en dropped during byte 0: word still finishes, next word not fetched
    got_a.delete();
    base_rd = n_rd_a; base_wd = n_wd_a;
    qa.push_back(16'h1234);
    qa.push_back(16'hBEEF);
    @(negedge clk);
    en_a = 1'b1;
    for (int i = 0; i < 50 && !txr_a; i++) @(negedge clk);
    en_a = 1'b0;
    for (int i = 0; i < 400 && n_wd_a < base_wd + 1; i++) @(negedge clk);
    repeat (60) @(negedge clk);
    check("t3_word_done", n_wd_a - base_wd, 1);
    check("t3_rd_pulses", n_rd_a - base_rd, 1);
    check("t3_byte0", got_a[0], 8'h34);
    check("t3_byte1", got_a[1], 8'h12);
    check("t3_fifo_left", qa.size(), 1);

    // Reset while waiting for byte 1 to finish
    got_a.delete();
    en_a = 1'b1;
    for (int i = 0; i < 400 && got_a.size() < 2; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("t4_pre_busy", busy_a, 1'b1);
    #2 RST_N = 1'b0;
    #1 check("t4_async_reset", {rd_a, txr_a, dout_a, busy_a, wd_a, ae_a}, 13'h0);
    @(negedge clk);
    RST_N = 1'b1;
    got_a.delete();
    base_wd = n_wd_a;
    qa.push_back(16'hC33C);
    for (int i = 0; i < 400 && n_wd_a < base_wd + 1; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("t4_word_done", n_wd_a - base_wd, 1);
    check("t4_byte0", got_a[0], 8'h3C);
    check("t4_byte1", got_a[1], 8'hC3);
    check("a_handshake", viol_a, 0);
    check("a_no_ack_err", n_ae_a, 0);
    en_a = 1'b0;

    // 4-byte words, MSB first
    qb.push_back(32'h11223344);
    qb.push_back(32'hDEADBEEF);
    en_b = 1'b1;
    for (int i = 0; i < 800 && n_wd_b < 2; i++) @(negedge clk);
    en_b = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_word_done", n_wd_b, 2);
    check("t5_rd_pulses", n_rd_b, 2);
    check("t5_nbytes", got_b.size(), 8);
    for (int k = 0; k < 8; k++) check($sformatf("t5_byte%0d", k), got_b[k], exp_b[k]);
    check("t5_no_ack_err", n_ae_b, 0);

    // Silent transmitter: timeout, drop the word, fetch the next one
    got_b.delete();
    base_rd = n_rd_b; base_wd = n_wd_b;
    mute_b = 1'b1;
    qb.push_back(32'hAABBCCDD);
    qb.push_back(32'h01020304);
    @(negedge clk);
    en_b = 1'b1;
    for (int i = 0; i < 100 && n_ae_b < 1; i++) @(negedge clk);
    mute_b = 1'b0;
    check("t6_ack_err", n_ae_b, 1);
    check("t6_err_delay", t_ae_b - t_tx_b, 16);
    check("t6_txreq_low", ae_txr_b, 1'b0);
    for (int i = 0; i < 400 && n_wd_b < base_wd + 1; i++) @(negedge clk);
    en_b = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_word_done", n_wd_b - base_wd, 1);
    check("t6_rd_pulses", n_rd_b - base_rd, 2);
    check("t6_nbytes", got_b.size(), 4);
    check("t6_byte0", got_b[0], 8'h01);
    check("t6_byte3", got_b[3], 8'h04);
    check("t6_ack_err_once", n_ae_b, 1);
    check("b_handshake", viol_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_word_sender.md
# uart_word_sender

Parametrised FIFO-to-UART byte serialiser. It pops one WORD_BYTES-wide word from a synchronous show-next FIFO and splits it into bytes in a configurable order. Each byte is handed to the UART transmitter over a req/busy handshake, and a timeout recovers from a transmitter that never acknowledges. It sits between the capture FIFO and the UART TX core and generalises the fixed 16-bit, two-byte controller.

## Interface
- WORD_BYTES, 2, bytes per FIFO word (1..8); data_in width = 8*WORD_BYTES
- MSB_FIRST, 0, 0: send byte 0 (data_in[7:0]) first; 1: send the top byte first
- ACK_TIMEOUT, 1024, cycles allowed for tx_busy to rise after tx_req is asserted (≥2)
- SYS_CLK  in  1  system clock; all logic on the rising edge
- RST_N  in  1  asynchronous, active-low reset
- en  in  1  when high, the block may start a new word
- data_in  in  8*WORD_BYTES  FIFO read data, valid the cycle after rd_req
- rd_empty  in  1  FIFO empty flag
- rd_req  out  1  FIFO read strobe, one cycle per word
- data_out  out  8  byte to the UART TX
- tx_req  out  1  transmit request to the UART TX
- tx_busy  in  1  UART TX busy; rises on accept, falls when the byte is done
- busy  out  1  high in every state except IDLE
- word_done  out  1  one-cycle pulse after the last byte of a word completes
- ack_err  out  1  one-cycle pulse when ACK_TIMEOUT expires

## Operation
- Single registered FSM. All outputs are registered. No clock inversion: the FIFO shares SYS_CLK.
- States: IDLE, FETCH, LATCH, LOAD, ACK, DONE, ERR.
- IDLE: if en && !rd_empty && !tx_busy, go to FETCH. rd_req=1 is registered for exactly that cycle.
- FETCH: rd_req returns to 0; go to LATCH.
- LATCH: capture data_in into a shift register (latch_data); clear byte_idx; go to LOAD.
- LOAD: present the current byte on data_out, assert tx_req, clear the timeout counter; go to ACK.
  - Current byte is latch_data[8*byte_idx +: 8] when MSB_FIRST=0.
  - Current byte is latch_data[8*(WORD_BYTES-1-byte_idx) +: 8] when MSB_FIRST=1.
- ACK: hold tx_req=1 and data_out stable until tx_busy=1, then drop tx_req and go to DONE.
  - Timeout counter increments each cycle. On reaching ACK_TIMEOUT-1, go to ERR.
- DONE: wait for tx_busy=0.
  - If byte_idx==WORD_BYTES-1, pulse word_done and go to IDLE.
  - Otherwise increment byte_idx and go to LOAD.
- ERR: tx_req=0, pulse ack_err, and discard the rest of the word (no retry). Go to IDLE.
- en is sampled only in IDLE. Dropping en mid-word always finishes the current word.
- byte_idx width is clog2(WORD_BYTES) bits, minimum 1. Timeout counter width is clog2(ACK_TIMEOUT) bits. Neither counter wraps in legal operation.
- rd_empty is ignored outside IDLE. A FIFO that goes empty after rd_req does not affect the latched word.

## Timing
- Reset values: rd_req=0, tx_req=0, data_out=8'h00, busy=0, word_done=0, ack_err=0, state=IDLE, latch_data=0.
- Reset mid-word: all outputs return to their reset values immediately; the partial word is lost.
- Latency:
  - rd_req is high in cycle T.
  - data_in is latched at T+1.
  - tx_req first goes high at T+3.
  - busy is high from T through the cycle word_done pulses.
- Handshake:
  - tx_req never rises while tx_busy=1.
  - tx_req falls on the cycle after tx_busy is sampled high.
  - data_out changes only in LOAD.
- If tx_busy is already high when tx_req is asserted, that counts as accept.
- Minimum per-byte time is 3 cycles plus the UART busy time. There is no back-to-back overlap between words: at least 1 IDLE cycle separates them.
- Simultaneous events:
  - Timeout expiry and tx_busy rising in the same cycle: accept wins, and ack_err does not pulse.
  - word_done and a new rd_req never occur in the same cycle.

## Test plan
- WORD_BYTES=2, MSB_FIRST=0; FIFO holds 16'hA55A; UART model gives busy 10 cycles after each req → data_out 8'h5A then 8'hA5, one rd_req pulse, one word_done pulse, busy low afterwards.
- WORD_BYTES=4, MSB_FIRST=1; words 32'h11223344 and 32'hDEADBEEF → bytes 11,22,33,44,DE,AD,BE,EF in order, two rd_req pulses, two word_done pulses.
- rd_empty held at 1 with en=1 → rd_req, tx_req and busy stay 0 for 100 cycles.
- ACK_TIMEOUT=16; tx_busy held at 0 after the first LOAD → ack_err pulses exactly 16 cycles after tx_req rises, tx_req drops, no further bytes of that word are sent, FSM returns to IDLE and fetches the next word.
- en dropped during byte 0 of a 2-byte word → both bytes are still sent, word_done pulses, no further rd_req while en=0.
- RST_N asserted while in DONE on byte 1 → all outputs return to reset values within the same cycle; after release, the next FIFO word is sent from byte 0.
